// File: rtl/hdmi_packet_pkg.sv
// Shared geometry, types and BCH step for the HDMI data island packet serializer.
package hdmi_packet_pkg;

  localparam int PACKET_LEN  = 32;
  localparam int HEADER_BITS = 24;
  localparam int SUB_BITS    = 56;
  localparam int NUM_SUBS    = 4;
  localparam int CNT_W       = $clog2(PACKET_LEN);

  localparam logic [7:0] BCH_MASK = 8'h83;

  // Cycle counts at which payload ends and parity begins.
  localparam logic [CNT_W-1:0] HDR_CYCLES = 5'd24;
  localparam logic [CNT_W-1:0] SUB_CYCLES = 5'd28;

  typedef logic [NUM_SUBS-1:0][SUB_BITS-1:0] sub_array_t;

  // One LSB-first step of the x^8+x^7+x^6+1 generator.
  function automatic logic [7:0] next_ecc(input logic [7:0] e, input logic b);
    return (e >> 1) ^ ((e[0] ^ b) ? BCH_MASK : 8'h00);
  endfunction

endpackage

// File: rtl/bch_ecc.sv
// 8-bit BCH parity LFSR, advancing STEPS bits per enabled cycle, LSB first.
module bch_ecc
  import hdmi_packet_pkg::*;
#(
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_en,
  input  logic [STEPS-1:0] i_bits,
  output logic [7:0]       o_ecc
);

  logic [7:0] r_ecc;
  logic [7:0] w_next;

  // i_start seeds from zero so back-to-back packets need no separate clear.
  always_comb begin
    w_next = i_start ? 8'h00 : r_ecc;
    for (int i = 0; i < STEPS; i++) begin
      w_next = next_ecc(w_next, i_bits[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ecc <= 8'h00;
    end else if (i_en) begin
      r_ecc <= w_next;
    end
  end

  assign o_ecc = r_ecc;

endmodule

// File: rtl/data_island_packet_serializer.sv
// Serializes one 32-cycle HDMI data island packet (header + 4 subpackets + BCH parity)
// into the 9 per-pixel bits consumed by the TERC4 encoders.
module data_island_packet_serializer
  import hdmi_packet_pkg::*;
(
  input  logic                   clk_pixel,
  input  logic                   reset_n,
  input  logic                   data_island_period,
  input  logic [HEADER_BITS-1:0] header,
  input  sub_array_t             sub,
  output logic [CNT_W-1:0]       counter,
  output logic                   packet_load,
  output logic                   packet_valid,
  output logic [8:0]             packet_data
);

  logic [CNT_W-1:0]       r_counter;
  logic                   r_valid;
  logic [8:0]             r_data;
  logic [HEADER_BITS-1:0] r_header;
  sub_array_t             r_sub;

  logic                   w_load;
  logic                   w_hdr_phase;
  logic                   w_sub_phase;
  logic [HEADER_BITS-1:0] w_hdr;
  sub_array_t             w_sub;
  logic [CNT_W-1:0]       w_hidx;
  logic [CNT_W-1:0]       w_sbase;
  logic [CNT_W:0]         w_sidx_even;
  logic [CNT_W:0]         w_sidx_odd;
  logic [7:0]             w_hecc;
  logic [NUM_SUBS-1:0][7:0] w_secc;
  logic [8:0]             w_bits;

  assign w_load      = data_island_period && (r_counter == '0);
  assign w_hdr_phase = r_counter < HDR_CYCLES;
  assign w_sub_phase = r_counter < SUB_CYCLES;

  // The load cycle bypasses the shadow registers, which only capture on that edge.
  assign w_hdr = w_load ? header : r_header;
  assign w_sub = w_load ? sub    : r_sub;

  assign w_hidx      = w_hdr_phase ? r_counter : '0;
  assign w_sbase     = w_sub_phase ? r_counter : '0;
  assign w_sidx_even = {w_sbase, 1'b0};
  assign w_sidx_odd  = {w_sbase, 1'b1};

  bch_ecc #(.STEPS(1)) u_hecc (
    .clk     (clk_pixel),
    .rst_n   (reset_n),
    .i_start (w_load),
    .i_en    (data_island_period && w_hdr_phase),
    .i_bits  (w_hdr[w_hidx]),
    .o_ecc   (w_hecc)
  );

  for (genvar k = 0; k < NUM_SUBS; k++) begin : g_secc
    bch_ecc #(.STEPS(2)) u_secc (
      .clk     (clk_pixel),
      .rst_n   (reset_n),
      .i_start (w_load),
      .i_en    (data_island_period && w_sub_phase),
      .i_bits  ({w_sub[k][w_sidx_odd], w_sub[k][w_sidx_even]}),
      .o_ecc   (w_secc[k])
    );
  end

  // Parity cycles index the ECC by the low counter bits: c-24 = c[2:0], c-28 = c[1:0].
  always_comb begin
    w_bits    = '0;
    w_bits[0] = w_hdr_phase ? w_hdr[w_hidx] : w_hecc[r_counter[2:0]];
    for (int k = 0; k < NUM_SUBS; k++) begin
      if (w_sub_phase) begin
        w_bits[1+k] = w_sub[k][w_sidx_even];
        w_bits[5+k] = w_sub[k][w_sidx_odd];
      end else begin
        w_bits[1+k] = w_secc[k][{r_counter[1:0], 1'b0}];
        w_bits[5+k] = w_secc[k][{r_counter[1:0], 1'b1}];
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_counter <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_header  <= '0;
      r_sub     <= '0;
    end else begin
      r_counter <= data_island_period ? r_counter + 5'd1 : '0;
      r_valid   <= data_island_period;
      r_data    <= data_island_period ? w_bits : 9'h000;
      if (w_load) begin
        r_header <= header;
        r_sub    <= sub;
      end
    end
  end

  assign counter      = r_counter;
  assign packet_load  = w_load;
  assign packet_valid = r_valid;
  assign packet_data  = r_data;

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Self-checking bench: table vectors, directed corner sequences and random packets
// compared against a packet-level reference model.
module tb_data_island_packet_serializer;

  logic         clk_pixel;
  logic         reset_n;
  logic         data_island_period;
  logic [23:0]  header;
  logic [223:0] sub;
  logic [4:0]   counter;
  logic         packet_load;
  logic         packet_valid;
  logic [8:0]   packet_data;

  data_island_packet_serializer dut (
    .clk_pixel          (clk_pixel),
    .reset_n            (reset_n),
    .data_island_period (data_island_period),
    .header             (header),
    .sub                (sub),
    .counter            (counter),
    .packet_load        (packet_load),
    .packet_valid       (packet_valid),
    .packet_data        (packet_data)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_words [32];
  logic [8:0] obs [32];
  int         exp_cnt = 0;

  typedef struct {
    logic [23:0]  h;
    logic [223:0] s;
    int           idx;
    logic [8:0]   w;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Parity of an n-bit LSB-first message under x^8+x^7+x^6+1.
  function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
    logic [7:0] e;
    logic       fb;
    e = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = e[0] ^ bits[i];
      e  = e >> 1;
      if (fb) e = e ^ 8'h83;
    end
    return e;
  endfunction

  // A packet is the 32-bit header codeword plus four 64-bit subpacket codewords.
  task automatic build_packet(input logic [23:0] h, input logic [223:0] s);
    logic [31:0] hcw;
    logic [63:0] scw [4];
    hcw = {bch({40'h0, h}, 24), h};
    for (int k = 0; k < 4; k++) begin
      scw[k] = {bch({8'h0, s[56*k +: 56]}, 56), s[56*k +: 56]};
    end
    for (int c = 0; c < 32; c++) begin
      exp_words[c][0] = hcw[c];
      for (int k = 0; k < 4; k++) begin
        exp_words[c][1+k] = scw[k][2*c];
        exp_words[c][5+k] = scw[k][2*c+1];
      end
    end
  endtask

  function automatic logic [223:0] rand224();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at posedge+1: drive inputs, check packet_load, clock once, check outputs.
  task automatic step(input logic dip, input logic [23:0] h, input logic [223:0] s);
    int c;
    logic [8:0] exp_d;
    data_island_period = dip;
    header = h;
    sub = s;
    #1;
    chk("packet_load", {31'd0, packet_load}, {31'd0, (dip && exp_cnt == 0)});
    c = exp_cnt;
    if (dip) begin
      if (c == 0) build_packet(h, s);
      exp_d   = exp_words[c];
      exp_cnt = (c + 1) % 32;
    end else begin
      exp_d   = 9'h000;
      exp_cnt = 0;
    end
    @(posedge clk_pixel);
    #1;
    chk("counter", {27'd0, counter}, exp_cnt);
    chk("packet_valid", {31'd0, packet_valid}, {31'd0, dip});
    chk("packet_data", {23'd0, packet_data}, {23'd0, exp_d});
    obs[c] = packet_data;
  endtask

  // Upstream data is only valid in the load cycle; later cycles carry garbage.
  task automatic run_packet(input logic [23:0] h, input logic [223:0] s, input int trunc);
    for (int i = 0; i < 32; i++) begin
      if (i == trunc) begin
        step(1'b0, $urandom, rand224());
        return;
      end
      if (i == 0) step(1'b1, h, s);
      else        step(1'b1, 24'($urandom), rand224());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{24'h000000, 224'h0,                   0,  9'h000};
    tbl[1]  = '{24'h000001, 224'h0,                   0,  9'h001};
    tbl[2]  = '{24'h000001, 224'h0,                   1,  9'h000};
    tbl[3]  = '{24'h000001, 224'h0,                   24, 9'h000};
    tbl[4]  = '{24'h000001, 224'h0,                   25, 9'h001};
    tbl[5]  = '{24'h000001, 224'h0,                   30, 9'h001};
    tbl[6]  = '{24'h000001, 224'h0,                   31, 9'h000};
    tbl[7]  = '{24'h000000, 224'h3 << 112,            0,  9'h088};
    tbl[8]  = '{24'h000000, 224'h4,                   1,  9'h002};
    tbl[9]  = '{24'h000000, 224'h20 << 168,           2,  9'h100};
    tbl[10] = '{24'h800000, 224'h0,                   23, 9'h001};

    reset_n = 1'b0;
    data_island_period = 1'b0;
    header = '0;
    sub = '0;
    repeat (3) @(posedge clk_pixel);
    #1;
    chk("reset_counter", {27'd0, counter}, 0);
    chk("reset_valid", {31'd0, packet_valid}, 0);
    chk("reset_data", {23'd0, packet_data}, 0);
    reset_n = 1'b1;
    @(posedge clk_pixel);
    #1;

    // Null packets, back-to-back: loads at 0/32/64, all data zero.
    for (int p = 0; p < 3; p++) run_packet(24'h0, 224'h0, -1);
    step(1'b0, 24'h0, 224'h0);

    // Header parity of 24'h000001 is 8'h4A.
    run_packet(24'h000001, 224'h0, -1);
    for (int c = 24; c < 32; c++) begin
      chk("hdr_parity_bit", {31'd0, obs[c][0]}, {31'd0, 8'h4A >> (c - 24) & 8'h01});
    end

    for (int i = 0; i < 11; i++) begin
      run_packet(tbl[i].h, tbl[i].s, -1);
      chk($sformatf("table_%0d", i), {23'd0, obs[tbl[i].idx]}, {23'd0, tbl[i].w});
    end
    step(1'b0, 24'h0, 224'h0);

    // Island truncated at counter 17, then a fresh full packet.
    run_packet(24'($urandom), rand224(), 17);
    chk("trunc_counter", {27'd0, counter}, 0);
    step(1'b0, 24'h0, 224'h0);
    run_packet(24'($urandom), rand224(), -1);

    // Asynchronous reset between edges at counter 10.
    for (int i = 0; i < 10; i++) begin
      if (i == 0) step(1'b1, 24'hFFFFFF, rand224());
      else        step(1'b1, 24'($urandom), rand224());
    end
    chk("pre_reset_counter", {27'd0, counter}, 10);
    chk("pre_reset_data0", {31'd0, packet_data[0]}, 1);
    #2;
    reset_n = 1'b0;
    data_island_period = 1'b0;
    #1;
    chk("async_counter", {27'd0, counter}, 0);
    chk("async_valid", {31'd0, packet_valid}, 0);
    chk("async_data", {23'd0, packet_data}, 0);
    exp_cnt = 0;
    repeat (2) @(posedge clk_pixel);
    #2;
    reset_n = 1'b1;
    @(posedge clk_pixel);
    #1;
    run_packet(24'($urandom), rand224(), -1);
    run_packet(24'($urandom), rand224(), -1);

    // Random packets with occasional gaps and truncations.
    for (int p = 0; p < 30; p++) begin
      int trunc;
      trunc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 31)) : -1;
      run_packet(24'($urandom), rand224(), trunc);
      if ($urandom_range(0, 2) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) step(1'b0, 24'($urandom), rand224());
      end
    end
    step(1'b0, 24'h0, 224'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
